// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the 8N1 UART transmitter and receiver.
// Holds the default baud divider, frame width, FSM codes and a 2-of-3 vote.
package uart_pkg;

  // 50 MHz / 9600 baud; both ends of the link use this default
  localparam int UART_CLKS_PER_BIT = 5208;
  localparam int DATA_BITS         = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous bit.
// Ports: clk, reset (sync, active-high), d (async in), q (synchronised out).
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 UART receiver, LSB first, mid-bit sampling.
// Ports: clk_50M, reset (sync, active-high), uart_rxd (async line),
//   rx_data (last good byte), rx_valid / frame_err (1-cycle strobes),
//   rx_busy (not idle).
// Option: define UART_RX_MAJORITY_EN for 2-of-3 voting around each
//   sample point (decision one clock later).
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic                 clk_50M,
  input  logic                 reset,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 rx_busy
);

`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  // Start check lands at mid start bit; every later decision is
  // a whole bit period after it, so it also lands mid-bit.
  localparam logic [CNT_W-1:0] START_PT =
    CNT_W'(CLKS_PER_BIT / 2 - 1 + MAJ);
  localparam logic [CNT_W-1:0] BIT_END =
    CNT_W'(CLKS_PER_BIT - 1);

  logic rxd_s;
  logic bit_s;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk_50M),
    .reset(reset),
    .d    (uart_rxd),
    .q    (rxd_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Two older samples of rxd_s; the vote spans cnt-2..cnt.
  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = rxd_s;
    s2_d = s1_q;
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign bit_s = maj3(rxd_s, s1_q, s2_q);
`else
  assign bit_s = rxd_s;
`endif

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxd_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == START_PT) begin
          cnt_d = '0;
          if (!bit_s) begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end else begin
            // glitch shorter than half a bit
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d     = '0;
          shift_d   = {bit_s, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          if (bit_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // absorb a held-low line so it cannot retrigger
        cnt_d = '0;
        if (rxd_s) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign rx_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1: directed frames against an event-queue model of
// the receiver (expected byte/error and strobe cycle per frame).
module tb_uart_rx_8n1;

  localparam int CLKS = 16;
  localparam int HALF = CLKS / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // pin start edge -> strobe: 2 sync + 1 detect + half bit + 9 bits
  localparam int LAT = 3 + HALF + 9 * CLKS + MAJ;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  uart_rx_8n1 #(
    .CLKS_PER_BIT(CLKS)
  ) dut (
    .clk_50M  (clk),
    .reset    (reset),
    .uart_rxd (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic rst_seen = 1'b1;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  typedef struct {
    int         at;
    bit         err;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] model_data = 8'h00;
  int         last_valid_at = -1;
  bit         prev_strobe = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d",
               name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (rst_seen) begin
      exp_q.delete();
      model_data  = 8'h00;
      prev_strobe = 1'b0;
      chk("rst_valid", {31'd0, rx_valid}, 0);
      chk("rst_ferr", {31'd0, frame_err}, 0);
      chk("rst_busy", {31'd0, rx_busy}, 0);
      chk("rst_data", {24'd0, rx_data}, 0);
    end else begin
      if (rx_valid || frame_err) begin
        chk("strobe_gap", {31'd0, prev_strobe}, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe",
              {30'd0, rx_valid, frame_err}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_kind", {30'd0, rx_valid, frame_err},
              e.err ? 32'd1 : 32'd2);
          chk("strobe_cycle", cyc, e.at);
          if (!e.err) begin
            model_data    = e.data;
            last_valid_at = cyc;
          end
        end
      end else if (exp_q.size() != 0 && cyc >= exp_q[0].at) begin
        e = exp_q.pop_front();
        chk("missing_strobe", {30'd0, rx_valid, frame_err},
            e.err ? 32'd1 : 32'd2);
      end
      chk("rx_data", {24'd0, rx_data}, {24'd0, model_data});
      prev_strobe = rx_valid | frame_err;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one 10-bit frame; glitch_t inverts the pin for one clock.
  task automatic send(input logic [7:0] b, input bit stop,
                      input int glitch_t, input logic [7:0] exp_b,
                      output int c);
    logic [9:0] fr;
    ev_t        e;
    fr     = {stop, b, 1'b0};
    c      = cyc;
    e.at   = c + LAT;
    e.err  = !stop;
    e.data = exp_b;
    exp_q.push_back(e);
    for (int t = 0; t < 10 * CLKS; t++) begin
      rxd = fr[t / CLKS] ^ (t == glitch_t);
      @(negedge clk);
    end
  endtask

  initial begin
    int         c;
    logic [9:0] fr;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(4);

    send(8'h55, 1'b1, -1, 8'h55, c);
    chk("lit_55", {24'd0, rx_data}, 32'h55);
    chk("lit_latency", last_valid_at - c, 155 + MAJ);
    idle(CLKS);

    send(8'hA3, 1'b1, -1, 8'hA3, c);
    chk("lit_A3", {24'd0, rx_data}, 32'hA3);
    send(8'h00, 1'b1, -1, 8'h00, c);
    chk("lit_00", {24'd0, rx_data}, 32'h00);
    send(8'hFF, 1'b1, -1, 8'hFF, c);
    chk("lit_FF", {24'd0, rx_data}, 32'hFF);
    idle(CLKS);

    // short low pulse: false start, busy ends at start check
    c   = cyc;
    rxd = 1'b0;
    idle(5);
    rxd = 1'b1;
    idle(5 + MAJ);
    chk("false_busy_hi", {31'd0, rx_busy}, 1);
    idle(1);
    chk("false_busy_lo", {31'd0, rx_busy}, 0);
    idle(2 * CLKS);

    // bad stop bit, then held low as a break
    send(8'h3C, 1'b0, -1, 8'h00, c);
    idle(3 * CLKS);
    chk("break_busy", {31'd0, rx_busy}, 1);
    chk("break_keeps_data", {24'd0, rx_data}, 32'hFF);
    rxd = 1'b1;
    idle(2 * CLKS);
    send(8'h81, 1'b1, -1, 8'h81, c);
    chk("lit_81", {24'd0, rx_data}, 32'h81);
    idle(CLKS);

    // reset in the middle of data bit 4 of 0xF0
    fr = {1'b1, 8'hF0, 1'b0};
    for (int t = 0; t < 5 * CLKS + HALF; t++) begin
      rxd = fr[t / CLKS];
      @(negedge clk);
    end
    reset = 1'b1;
    rxd   = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    chk("mid_rst_busy", {31'd0, rx_busy}, 0);
    chk("mid_rst_data", {24'd0, rx_data}, 0);
    idle(2 * CLKS);
    send(8'h12, 1'b1, -1, 8'h12, c);
    chk("lit_12", {24'd0, rx_data}, 32'h12);
    idle(CLKS);

    // one-clock glitch on the mid sample of data bit 2
    send(8'h5A, 1'b1, HALF + 3 * CLKS,
         MAJ ? 8'h5A : 8'h5E, c);
    chk("lit_glitch", {24'd0, rx_data},
        MAJ ? 32'h5A : 32'h5E);
    idle(2 * CLKS);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
